// File: rtl/interboard_pkg.sv
// Shared definitions for the interboard link. Used by both the receive
// stage (recv_all) and the peer-side sender.
package interboard_pkg;

  localparam int WORD_W = 6;

  // The peer signals its own reset by raising Request with an all-ones word.
  localparam logic [WORD_W-1:0] RST_WORD = 6'h3F;

  localparam int MSG_TYPE_W = 4;
  localparam int BLOCK_X_W  = 5;
  localparam int BLOCK_Y_W  = 3;
  localparam int CARD_W     = 6;
  localparam int SEL_LEN_W  = 3;
  localparam int MOVE_DIR_W = 1;

  // Word-level handshake states
  typedef enum logic [1:0] {
    WAIT_REQ  = 2'd0,
    CHECK_RST = 2'd1,
    ACK_HI    = 2'd2
  } word_st_e;

  // Position of each word within a move frame
  typedef enum logic [2:0] {
    MSG_TYPE = 3'd0,
    BLOCK_X  = 3'd1,
    BLOCK_Y  = 3'd2,
    CARD     = 3'd3,
    SEL_LEN  = 3'd4,
    MOVE_DIR = 3'd5
  } step_e;

  typedef struct packed {
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [BLOCK_X_W-1:0]  block_x;
    logic [BLOCK_Y_W-1:0]  block_y;
    logic [CARD_W-1:0]     card;
    logic [SEL_LEN_W-1:0]  sel_len;
    logic [MOVE_DIR_W-1:0] move_dir;
  } frame_t;

endpackage

// File: rtl/recv_all_if.sv
// Interboard link plus the decoded-frame outputs presented to GameControl.
// slave: the receive stage. master: the peer / frame consumer side.
interface recv_all_if;
  import interboard_pkg::*;

  logic                  Request;
  logic [WORD_W-1:0]     interboard_data;
  logic                  Ack;

  logic                  recv_en;
  logic [MSG_TYPE_W-1:0] recv_msg_type;
  logic [BLOCK_X_W-1:0]  recv_block_x;
  logic [BLOCK_Y_W-1:0]  recv_block_y;
  logic [CARD_W-1:0]     recv_card;
  logic [SEL_LEN_W-1:0]  recv_sel_len;
  logic [MOVE_DIR_W-1:0] recv_move_dir;
  logic                  peer_rst;
  logic                  frame_err;

  modport slave (
    input  Request, interboard_data,
    output Ack, recv_en, recv_msg_type, recv_block_x, recv_block_y,
           recv_card, recv_sel_len, recv_move_dir, peer_rst, frame_err
  );

  modport master (
    output Request, interboard_data,
    input  Ack, recv_en, recv_msg_type, recv_block_x, recv_block_y,
           recv_card, recv_sel_len, recv_move_dir, peer_rst, frame_err
  );
endinterface

// File: rtl/recv_all_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs (module sync_2ff).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [1:0][W-1:0] pipe;

  // shift the async input through two flops
  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[0], d};
  end

  assign q = pipe[1];
endmodule

// File: rtl/recv_all.sv
// Receive side of the interboard link: 4-phase Request/Ack word handshake,
// six-word move-frame reassembly and peer-reset detection.
// Optional macro RECV_FRAME_TIMEOUT_EN adds an inter-word timeout that
// aborts a stalled frame and reports it on frame_err.
module recv_all
  import interboard_pkg::*;
#(
  parameter int RST_WAIT = 16
`ifdef RECV_FRAME_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1048575
`endif
) (
  input  logic       clk,
  input  logic       rst,
  recv_all_if.slave  bus
);
  localparam int CW = $clog2(RST_WAIT + 1);

  word_st_e          state, state_nxt;
  logic              req_s;
  logic [WORD_W-1:0] word_reg;
  step_e             step;
  logic [CW-1:0]     cnt;
  frame_t            sh, frm;
  logic              ack_q, recv_en_q, peer_rst_q;
  logic              ld_word, wr_field, prst_hit;

  sync_2ff #(.W(1)) u_req_sync (.clk(clk), .rst(rst), .d(bus.Request), .q(req_s));

`ifdef RECV_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          to_run, to_hit, frame_err_q;

  // timeout runs while a frame is open and the peer is not progressing
  assign to_run = (state == WAIT_REQ && step != MSG_TYPE) || (state == ACK_HI && req_s);
`endif

  // word FSM next state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    ld_word   = 1'b0;
    wr_field  = 1'b0;
    prst_hit  = 1'b0;
`ifdef RECV_FRAME_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    unique case (state)
      WAIT_REQ: if (req_s) begin
        ld_word   = 1'b1;
        state_nxt = (bus.interboard_data == RST_WORD) ? CHECK_RST : ACK_HI;
      end
      CHECK_RST: begin
        // a 3F word withdrawn without Ack is the peer resetting itself;
        // one still held after RST_WAIT cycles is genuine data
        if (!req_s) begin
          prst_hit  = 1'b1;
          state_nxt = WAIT_REQ;
        end else if (cnt == CW'(RST_WAIT - 1)) begin
          state_nxt = ACK_HI;
        end
      end
      ACK_HI: if (!req_s) begin
        wr_field  = 1'b1;
        state_nxt = WAIT_REQ;
      end
      default: state_nxt = WAIT_REQ;
    endcase
`ifdef RECV_FRAME_TIMEOUT_EN
    if (to_run && tcnt == TW'(TIMEOUT_CYC - 1)) begin
      to_hit    = 1'b1;
      ld_word   = 1'b0;
      wr_field  = 1'b0;
      state_nxt = WAIT_REQ;
    end
`endif
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_REQ;
    else     state <= state_nxt;
  end

  // word capture, field shadows, step counter and output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg   <= '0;
      step       <= MSG_TYPE;
      cnt        <= '0;
      sh         <= '0;
      frm        <= '0;
      ack_q      <= 1'b0;
      recv_en_q  <= 1'b0;
      peer_rst_q <= 1'b0;
    end else begin
      recv_en_q  <= 1'b0;
      peer_rst_q <= prst_hit;
      ack_q      <= (state_nxt == ACK_HI);
      cnt        <= (state == CHECK_RST) ? cnt + 1'b1 : '0;
      if (ld_word) word_reg <= bus.interboard_data;
      if (prst_hit) begin
        step <= MSG_TYPE;
        sh   <= '0;
      end else if (wr_field) begin
        unique case (step)
          MSG_TYPE: sh.msg_type <= word_reg[MSG_TYPE_W-1:0];
          BLOCK_X:  sh.block_x  <= word_reg[BLOCK_X_W-1:0];
          BLOCK_Y:  sh.block_y  <= word_reg[BLOCK_Y_W-1:0];
          CARD:     sh.card     <= word_reg[CARD_W-1:0];
          SEL_LEN:  sh.sel_len  <= word_reg[SEL_LEN_W-1:0];
          MOVE_DIR: sh.move_dir <= word_reg[MOVE_DIR_W-1:0];
          default:  ;
        endcase
        if (step == MOVE_DIR) begin
          // last word goes straight to the outputs so the frame lands in one edge
          step      <= MSG_TYPE;
          recv_en_q <= 1'b1;
          frm       <= '{msg_type: sh.msg_type, block_x: sh.block_x,
                         block_y: sh.block_y, card: sh.card,
                         sel_len: sh.sel_len,
                         move_dir: word_reg[MOVE_DIR_W-1:0]};
        end else begin
          step <= step_e'(step + 3'd1);
        end
      end
`ifdef RECV_FRAME_TIMEOUT_EN
      if (to_hit) step <= MSG_TYPE;
`endif
    end
  end

`ifdef RECV_FRAME_TIMEOUT_EN
  // inter-word timeout counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= to_hit;
      if (to_hit || state_nxt != state || !to_run) tcnt <= '0;
      else                                         tcnt <= tcnt + 1'b1;
    end
  end
  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.Ack           = ack_q;
  assign bus.recv_en       = recv_en_q;
  assign bus.peer_rst      = peer_rst_q;
  assign bus.recv_msg_type = frm.msg_type;
  assign bus.recv_block_x  = frm.block_x;
  assign bus.recv_block_y  = frm.block_y;
  assign bus.recv_card     = frm.card;
  assign bus.recv_sel_len  = frm.sel_len;
  assign bus.recv_move_dir = frm.move_dir;
endmodule

// File: tb/tb_recv_all.sv
// Bench for recv_all: a behavioural peer drives the 4-phase handshake,
// expected frames come from the word->field narrowing rules.
module tb_recv_all;
  localparam int RST_WAIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  recv_all_if ifc();

  recv_all #(
    .RST_WAIT(RST_WAIT)
`ifdef RECV_FRAME_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks = 0, failures = 0;
  int ack_rises = 0, n_en = 0, n_prst = 0, n_ferr = 0, stab_err = 0;
  logic ack_prev = 1'b0;
  logic [21:0] prev_f = '0;
  logic [21:0] got_q[$];
  logic [21:0] exp_q[$];

  // observer on the falling edge: pulse counts, captured frames, field stability
  always @(negedge clk) begin
    logic [21:0] cur;
    cur = {ifc.recv_msg_type, ifc.recv_block_x, ifc.recv_block_y,
           ifc.recv_card, ifc.recv_sel_len, ifc.recv_move_dir};
    if (ifc.Ack === 1'b1 && ack_prev !== 1'b1) ack_rises++;
    ack_prev = ifc.Ack;
    if (ifc.recv_en === 1'b1) begin n_en++; got_q.push_back(cur); end
    if (ifc.peer_rst === 1'b1) n_prst++;
    if (ifc.frame_err === 1'b1) n_ferr++;
    if (!rst && cur !== prev_f && ifc.recv_en !== 1'b1) stab_err++;
    prev_f = cur;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag);
    checks++;
    failures++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  function automatic logic [21:0] fexp(input logic [5:0] w [6]);
    return {4'(w[0] % 16), 5'(w[1] % 32), 3'(w[2] % 8), w[3], 3'(w[4] % 8), 1'(w[5] % 2)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one compliant 4-phase word; returns cycles to Ack high and to Ack low
  task automatic send_word(input logic [5:0] w, output int lat_hi, output int lat_lo);
    @(negedge clk);
    ifc.interboard_data = w;
    ifc.Request = 1'b1;
    lat_hi = 0;
    while (ifc.Ack !== 1'b1 && lat_hi < 200) begin @(negedge clk); lat_hi++; end
    if (lat_hi >= 200) expire("ack_rise");
    ifc.Request = 1'b0;
    lat_lo = 0;
    while (ifc.Ack !== 1'b0 && lat_lo < 200) begin @(negedge clk); lat_lo++; end
    if (lat_lo >= 200) expire("ack_fall");
  endtask

  task automatic send_frame(input logic [5:0] w [6], input int max_gap);
    int hi, lo;
    for (int i = 0; i < 6; i++) begin
      send_word(w[i], hi, lo);
      chk($sformatf("ack_lat_w%0d", i), hi, (w[i] == 6'h3F) ? 3 + RST_WAIT : 3);
      if (i < 5 && max_gap > 0) idle($urandom_range(0, max_gap));
    end
    chk("recv_en_lat", lo, 3);
    chk("recv_en_at_fall", ifc.recv_en, 1'b1);
    exp_q.push_back(fexp(w));
  endtask

  task automatic verify_frames();
    while (exp_q.size() > 0) begin
      if (got_q.size() == 0) begin
        void'(exp_q.pop_front());
        expire("frame_missing");
      end else begin
        chk("frame", got_q.pop_front(), exp_q.pop_front());
      end
    end
    chk("extra_frames", got_q.size(), 0);
  endtask

  initial begin
    logic [5:0] w [6];
    int hi, lo, a0, e0, p0, n;
    ifc.Request = 1'b0;
    ifc.interboard_data = '0;
    idle(3);
    chk("rst_ack", ifc.Ack, 0);
    chk("rst_recv_en", ifc.recv_en, 0);
    chk("rst_fields", {ifc.recv_msg_type, ifc.recv_block_x, ifc.recv_block_y,
                       ifc.recv_card, ifc.recv_sel_len, ifc.recv_move_dir}, 0);
    chk("rst_peer_rst", ifc.peer_rst, 0);
    chk("rst_frame_err", ifc.frame_err, 0);
    rst = 1'b0;
    idle(3);

    // nominal frame
    a0 = ack_rises; e0 = n_en;
    w = '{6'h02, 6'd17, 6'd5, 6'd42, 6'd3, 6'd1};
    send_frame(w, 0);
    idle(4);
    chk("nom_ack_toggles", ack_rises - a0, 6);
    chk("nom_recv_en", n_en - e0, 1);
    chk("nom_msg_type", ifc.recv_msg_type, 2);
    chk("nom_block_x", ifc.recv_block_x, 17);
    chk("nom_block_y", ifc.recv_block_y, 5);
    chk("nom_card", ifc.recv_card, 42);
    chk("nom_sel_len", ifc.recv_sel_len, 3);
    chk("nom_move_dir", ifc.recv_move_dir, 1);
    verify_frames();

    // peer reset after a partial frame: 3F held 12 cycles then withdrawn
    send_word(6'd9, hi, lo);
    send_word(6'd10, hi, lo);
    a0 = ack_rises; p0 = n_prst; e0 = n_en;
    @(negedge clk);
    ifc.interboard_data = 6'h3F;
    ifc.Request = 1'b1;
    idle(12);
    ifc.Request = 1'b0;
    idle(6);
    chk("prst_no_ack", ack_rises - a0, 0);
    chk("prst_pulse", n_prst - p0, 1);
    w = '{6'h3A, 6'd30, 6'd7, 6'd11, 6'd6, 6'd0};
    send_frame(w, 0);
    idle(4);
    chk("prst_no_spurious_en", n_en - e0, 1);
    verify_frames();

    // legitimate 63 as the card word
    p0 = n_prst;
    w = '{6'd1, 6'd3, 6'd2, 6'h3F, 6'd1, 6'd1};
    send_frame(w, 0);
    idle(4);
    chk("card63_no_prst", n_prst - p0, 0);
    chk("card63_value", ifc.recv_card, 63);
    verify_frames();

    // local reset while word2 is acknowledged
    e0 = n_en;
    send_word(6'd4, hi, lo);
    send_word(6'd8, hi, lo);
    @(negedge clk);
    ifc.interboard_data = 6'd6;
    ifc.Request = 1'b1;
    n = 0;
    while (ifc.Ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) expire("midrst_ack");
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ack_drop", ifc.Ack, 0);
    ifc.Request = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    chk("midrst_no_en", n_en - e0, 0);
    w = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd0};
    send_frame(w, 0);
    idle(4);
    chk("midrst_msg_type", ifc.recv_msg_type, 1);
    chk("midrst_move_dir", ifc.recv_move_dir, 0);
    verify_frames();

    // back-to-back frames, no idle gap
    e0 = n_en;
    w = '{6'h2F, 6'h3E, 6'h15, 6'h21, 6'h0F, 6'h22};
    send_frame(w, 0);
    w = '{6'h10, 6'h01, 6'h38, 6'h00, 6'h3B, 6'h13};
    send_frame(w, 0);
    idle(4);
    chk("b2b_pulses", n_en - e0, 2);
    verify_frames();

    // randomized frames with small random gaps
    for (int f = 0; f < 8; f++) begin
      foreach (w[i]) w[i] = 6'($urandom_range(0, 63));
      send_frame(w, 3);
    end
    idle(4);
    verify_frames();

`ifdef RECV_FRAME_TIMEOUT_EN
    // stall after word1; frame aborts after TIMEOUT_CYC idle cycles
    n = n_ferr;
    send_word(6'd5, hi, lo);
    send_word(6'd6, hi, lo);
    lo = 0;
    while (ifc.frame_err !== 1'b1 && lo < 300) begin @(negedge clk); lo++; end
    if (lo >= 300) expire("timeout_pulse");
    chk("timeout_latency", lo, 100);
    idle(3);
    chk("timeout_one_pulse", n_ferr - n, 1);
    w = '{6'd7, 6'd8, 6'd1, 6'd2, 6'd3, 6'd1};
    send_frame(w, 0);
    idle(4);
    verify_frames();
`else
    chk("no_frame_err", n_ferr, 0);
`endif

    chk("field_stability", stab_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
